// File: rtl/exec_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, multiplier FSM states, flag bit positions.
package exec_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] ALU_XOR  = 5'd2;
  localparam logic [OPC_W-1:0] ALU_AND  = 5'd3;
  localparam logic [OPC_W-1:0] ALU_OR   = 5'd4;
  localparam logic [OPC_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [OPC_W-1:0] ALU_SRA  = 5'd6;
  localparam logic [OPC_W-1:0] ALU_ROR  = 5'd7;
  localparam logic [OPC_W-1:0] ALU_LLB  = 5'd8;
  localparam logic [OPC_W-1:0] ALU_LHB  = 5'd9;
  localparam logic [OPC_W-1:0] ALU_PASS = 5'd10;
  localparam logic [OPC_W-1:0] ALU_MUL  = 5'd11;

  // flag = {Z, V, N}
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } fsm_state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, keeps the low DATA_W bits.
module exec_mul_iter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  import exec_pkg::*;

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  fsm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Next state, shift-add step and the busy (stall) indication.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy     = 1'b1;
          state_d  = StBusy;
          cnt_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins in every state and releases the stall in the same cycle.
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      busy    = 1'b0;
    end
    // No stall may be reported while the core is held in reset.
    if (!rst_n) busy = 1'b0;
  end

  assign done    = (state_q == StDone);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage_fwd.sv
// EX stage: two-level operand forwarding, single-cycle ALU, iterative MUL, EX/MEM register, flags.
module execute_stage_fwd #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic [1:0]        id_memtoreg,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic              id_alusrc,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [DATA_W-1:0] id_reg2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1addr,
  input  logic [REG_AW-1:0] id_rs2addr,
  input  logic [REG_AW-1:0] id_rdaddr,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_regwraddr,
  input  logic [DATA_W-1:0] mem_aluresult,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_regwraddr,
  input  logic [DATA_W-1:0] wb_regwrdata,
  output logic              ex_stall,
  output logic              ex_valid_out,
  output logic              ex_regwrite_out,
  output logic [1:0]        ex_memtoreg_out,
  output logic              ex_memread_out,
  output logic              ex_memwrite_out,
  output logic [DATA_W-1:0] ex_alu_out,
  output logic [DATA_W-1:0] ex_store_data_out,
  output logic [REG_AW-1:0] ex_regwraddr_out,
  output logic [2:0]        flag
);
  import exec_pkg::*;

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W-1:0] src1_fwd, src2_fwd, op2;
  logic [DATA_W-1:0] alu_res, mul_product;
  logic [3:0]        shamt;
  logic              upd_znv, upd_z, ovf;
  logic              mul_start, mul_done, commit;

  // Forwarding: WB applied first so a matching MEM result overrides it.
  always_comb begin
    src1_fwd = id_reg1;
    src2_fwd = id_reg2;
    if (wb_regwrite && wb_regwraddr == id_rs1addr && id_rs1addr != '0) src1_fwd = wb_regwrdata;
    if (wb_regwrite && wb_regwraddr == id_rs2addr && id_rs2addr != '0) src2_fwd = wb_regwrdata;
    // A load in MEM has no data yet, so it is never a forwarding source.
    if (mem_regwrite && !mem_memread && mem_regwraddr == id_rs1addr && id_rs1addr != '0) begin
      src1_fwd = mem_aluresult;
    end
    if (mem_regwrite && !mem_memread && mem_regwraddr == id_rs2addr && id_rs2addr != '0) begin
      src2_fwd = mem_aluresult;
    end
  end

  assign op2   = id_alusrc ? id_imm : src2_fwd;
  assign shamt = op2[3:0];

  // ALU result and which flags the operation is allowed to update.
  always_comb begin
    alu_res = '0;
    upd_znv = 1'b0;
    upd_z   = 1'b0;
    ovf     = 1'b0;
    case (id_aluop)
      OP_W'(ALU_ADD): begin
        alu_res = src1_fwd + op2;
        ovf     = (src1_fwd[MSB] == op2[MSB]) && (alu_res[MSB] != src1_fwd[MSB]);
        upd_znv = 1'b1;
      end
      OP_W'(ALU_SUB): begin
        alu_res = src1_fwd - op2;
        ovf     = (src1_fwd[MSB] != op2[MSB]) && (alu_res[MSB] != src1_fwd[MSB]);
        upd_znv = 1'b1;
      end
      OP_W'(ALU_XOR): begin alu_res = src1_fwd ^ op2;             upd_z = 1'b1; end
      OP_W'(ALU_AND): begin alu_res = src1_fwd & op2;             upd_z = 1'b1; end
      OP_W'(ALU_OR):  begin alu_res = src1_fwd | op2;             upd_z = 1'b1; end
      OP_W'(ALU_SLL): begin alu_res = src1_fwd << shamt;          upd_z = 1'b1; end
      OP_W'(ALU_SRA): begin alu_res = $signed(src1_fwd) >>> shamt; upd_z = 1'b1; end
      OP_W'(ALU_ROR): begin
        // A zero amount shifts the left term out entirely, leaving the operand unchanged.
        alu_res = (src1_fwd >> shamt) | (src1_fwd << (DATA_W - 32'(shamt)));
        upd_z   = 1'b1;
      end
      OP_W'(ALU_LLB):  alu_res = {src1_fwd[DATA_W-1:8], op2[7:0]};
      OP_W'(ALU_LHB):  alu_res = {op2[7:0], src1_fwd[DATA_W-9:0]};
      OP_W'(ALU_PASS): alu_res = op2;
      OP_W'(ALU_MUL):  alu_res = mul_done ? mul_product : '0;
      default:         alu_res = '0;
    endcase
  end

  assign mul_start = id_valid && (id_aluop == OP_W'(ALU_MUL));

  exec_mul_iter #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .abort  (flush),
    .op_a   (src1_fwd),
    .op_b   (op2),
    .busy   (ex_stall),
    .done   (mul_done),
    .product(mul_product)
  );

  assign commit = id_valid && !flush && !ex_stall;

  // EX/MEM register: real result on commit, otherwise an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_out      <= 1'b0;
      ex_regwrite_out   <= 1'b0;
      ex_memtoreg_out   <= '0;
      ex_memread_out    <= 1'b0;
      ex_memwrite_out   <= 1'b0;
      ex_alu_out        <= '0;
      ex_store_data_out <= '0;
      ex_regwraddr_out  <= '0;
    end else if (commit) begin
      ex_valid_out      <= 1'b1;
      ex_regwrite_out   <= id_regwrite;
      ex_memtoreg_out   <= id_memtoreg;
      ex_memread_out    <= id_memread;
      ex_memwrite_out   <= id_memwrite;
      ex_alu_out        <= alu_res;
      ex_store_data_out <= src2_fwd;
      ex_regwraddr_out  <= id_rdaddr;
    end else begin
      ex_valid_out      <= 1'b0;
      ex_regwrite_out   <= 1'b0;
      ex_memtoreg_out   <= '0;
      ex_memread_out    <= 1'b0;
      ex_memwrite_out   <= 1'b0;
      ex_alu_out        <= '0;
      ex_store_data_out <= '0;
      ex_regwraddr_out  <= '0;
    end
  end

  // Flags change only on commit; logic/shift ops touch Z alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= '0;
    end else if (commit) begin
      if (upd_znv) begin
        flag[FLAG_Z] <= (alu_res == '0);
        flag[FLAG_V] <= ovf;
        flag[FLAG_N] <= alu_res[MSB];
      end else if (upd_z) begin
        flag[FLAG_Z] <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_fwd.sv
// Directed bench for execute_stage_fwd with a behavioural reference model and per-cycle compare.
module tb_execute_stage_fwd;
  import exec_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int OW = 5;

  logic          clk, rst_n;
  logic          id_valid, id_regwrite, id_memread, id_memwrite, id_alusrc;
  logic [1:0]    id_memtoreg;
  logic [OW-1:0] id_aluop;
  logic [DW-1:0] id_reg1, id_reg2, id_imm;
  logic [AW-1:0] id_rs1addr, id_rs2addr, id_rdaddr;
  logic          flush;
  logic          mem_regwrite, mem_memread, wb_regwrite;
  logic [AW-1:0] mem_regwraddr, wb_regwraddr;
  logic [DW-1:0] mem_aluresult, wb_regwrdata;
  logic          ex_stall, ex_valid_out, ex_regwrite_out, ex_memread_out, ex_memwrite_out;
  logic [1:0]    ex_memtoreg_out;
  logic [DW-1:0] ex_alu_out, ex_store_data_out;
  logic [AW-1:0] ex_regwraddr_out;
  logic [2:0]    flag;

  execute_stage_fwd #(.DATA_W(DW), .REG_AW(AW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_imm(id_imm), .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr), .id_rdaddr(id_rdaddr),
    .flush(flush), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_regwraddr(mem_regwraddr), .mem_aluresult(mem_aluresult), .wb_regwrite(wb_regwrite),
    .wb_regwraddr(wb_regwraddr), .wb_regwrdata(wb_regwrdata), .ex_stall(ex_stall),
    .ex_valid_out(ex_valid_out), .ex_regwrite_out(ex_regwrite_out),
    .ex_memtoreg_out(ex_memtoreg_out), .ex_memread_out(ex_memread_out),
    .ex_memwrite_out(ex_memwrite_out), .ex_alu_out(ex_alu_out),
    .ex_store_data_out(ex_store_data_out), .ex_regwraddr_out(ex_regwraddr_out), .flag(flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic          e_valid = 1'b0, e_regwrite = 1'b0, e_memread = 1'b0, e_memwrite = 1'b0;
  logic [1:0]    e_memtoreg = '0;
  logic [DW-1:0] e_alu = '0, e_store = '0, m_prod = '0;
  logic [AW-1:0] e_rd = '0;
  logic [2:0]    m_flag = '0;
  int            m_phase = 0;  // edges since MUL issue, 0 when no MUL in flight

  function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] s, input logic [DW-1:0] rf);
    if (s != 0 && mem_regwrite && !mem_memread && mem_regwraddr == s) return mem_aluresult;
    if (s != 0 && wb_regwrite && wb_regwraddr == s) return wb_regwrdata;
    return rf;
  endfunction

  function automatic logic [DW-1:0] m_op2();
    return id_alusrc ? id_imm : m_fwd(id_rs2addr, id_reg2);
  endfunction

  // MUL issued in cycle T stalls cycles T .. T+DW.
  function automatic logic m_stall();
    if (!rst_n || flush) return 1'b0;
    if (m_phase == 0) return id_valid && id_aluop == ALU_MUL;
    return m_phase <= DW;
  endfunction

  function automatic logic [DW-1:0] m_result(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] p);
    int sa, sb, s;
    logic [DW-1:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = int'(b[3:0]);
    r  = '0;
    case (op)
      ALU_ADD:  r = 16'(sa + sb);
      ALU_SUB:  r = 16'(sa - sb);
      ALU_XOR:  r = a ^ b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_SLL:  r = a << s;
      ALU_SRA:  r = 16'(sa >>> s);
      ALU_ROR: begin
        r = a;
        for (int k = 0; k < s; k++) r = {r[0], r[DW-1:1]};
      end
      ALU_LLB:  r = {a[15:8], b[7:0]};
      ALU_LHB:  r = {b[7:0], a[7:0]};
      ALU_PASS: r = b;
      ALU_MUL:  r = p;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] m_flags(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [DW-1:0] r,
                                         input logic [2:0] cur);
    int sum;
    case (op)
      ALU_ADD, ALU_SUB: begin
        sum = (op == ALU_ADD) ? int'($signed(a)) + int'($signed(b))
                              : int'($signed(a)) - int'($signed(b));
        return {r == '0, (sum > 32767) || (sum < -32768), r[DW-1]};
      end
      ALU_XOR, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA, ALU_ROR: return {r == '0, cur[1:0]};
      default: return cur;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0; e_regwrite <= 1'b0; e_memread <= 1'b0; e_memwrite <= 1'b0;
      e_memtoreg <= '0; e_alu <= '0; e_store <= '0; e_rd <= '0;
      m_flag <= '0; m_phase <= 0; m_prod <= '0;
    end else begin
      if (id_valid && !flush && !m_stall()) begin
        e_valid <= 1'b1; e_regwrite <= id_regwrite; e_memread <= id_memread;
        e_memwrite <= id_memwrite; e_memtoreg <= id_memtoreg; e_rd <= id_rdaddr;
        e_store <= m_fwd(id_rs2addr, id_reg2);
        e_alu <= m_result(id_aluop, m_fwd(id_rs1addr, id_reg1), m_op2(), m_prod);
        m_flag <= m_flags(id_aluop, m_fwd(id_rs1addr, id_reg1), m_op2(),
                          m_result(id_aluop, m_fwd(id_rs1addr, id_reg1), m_op2(), m_prod), m_flag);
      end else begin
        e_valid <= 1'b0; e_regwrite <= 1'b0; e_memread <= 1'b0; e_memwrite <= 1'b0;
        e_memtoreg <= '0; e_alu <= '0; e_store <= '0; e_rd <= '0;
      end
      if (flush) m_phase <= 0;
      else if (m_phase == 0) begin
        if (id_valid && id_aluop == ALU_MUL) begin
          m_phase <= 1;
          m_prod  <= 16'(int'(m_fwd(id_rs1addr, id_reg1)) * int'(m_op2()));
        end
      end else if (m_phase <= DW) m_phase <= m_phase + 1;
      else m_phase <= 0;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("ex_stall", 32'(ex_stall), 32'(m_stall()));
    check("ex_valid_out", 32'(ex_valid_out), 32'(e_valid));
    check("ex_regwrite_out", 32'(ex_regwrite_out), 32'(e_regwrite));
    check("ex_memtoreg_out", 32'(ex_memtoreg_out), 32'(e_memtoreg));
    check("ex_memread_out", 32'(ex_memread_out), 32'(e_memread));
    check("ex_memwrite_out", 32'(ex_memwrite_out), 32'(e_memwrite));
    check("ex_alu_out", 32'(ex_alu_out), 32'(e_alu));
    check("ex_store_data_out", 32'(ex_store_data_out), 32'(e_store));
    check("ex_regwraddr_out", 32'(ex_regwraddr_out), 32'(e_rd));
    check("flag", 32'(flag), 32'(m_flag));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_regwrite = 0; id_memtoreg = 0; id_memread = 0; id_memwrite = 0;
    id_aluop = ALU_ADD; id_alusrc = 0; id_reg1 = 0; id_reg2 = 0; id_imm = 0;
    id_rs1addr = 1; id_rs2addr = 2; id_rdaddr = 5;
  endtask

  task automatic hz_clear();
    mem_regwrite = 0; mem_memread = 0; mem_regwraddr = 0; mem_aluresult = 0;
    wb_regwrite = 0; wb_regwraddr = 0; wb_regwrdata = 0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] imm, input logic alusrc);
    idle();
    id_valid = 1; id_regwrite = 1; id_aluop = op; id_reg1 = a; id_reg2 = b;
    id_imm = imm; id_alusrc = alusrc;
  endtask

  // Hand-computed pins on both the DUT and the model.
  task automatic expect_out(input string name, input logic [DW-1:0] alu, input logic [2:0] f,
                            input logic v);
    check({name, "_alu"}, 32'(ex_alu_out), 32'(alu));
    check({name, "_flag"}, 32'(flag), 32'(f));
    check({name, "_valid"}, 32'(ex_valid_out), 32'(v));
    check({name, "_model"}, 32'(e_alu), 32'(alu));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic gone;
    idle(); hz_clear(); flush = 0; rst_n = 0;
    #3;
    check("rst_stall", 32'(ex_stall), 0);
    expect_out("rst", 16'h0000, 3'b000, 1'b0);
    #9 rst_n = 1;
    cyc();

    issue(ALU_ADD, 16'h7FFF, 16'h0001, 0, 0); cyc(); expect_out("add_ovf", 16'h8000, 3'b011, 1);
    check("add_rd", 32'(ex_regwraddr_out), 5);

    // Double hazard on rs1=3: MEM beats WB.
    issue(ALU_ADD, 16'h0555, 16'h0001, 0, 0); id_rs1addr = 3;
    mem_regwrite = 1; mem_regwraddr = 3; mem_aluresult = 16'h0011;
    wb_regwrite = 1; wb_regwraddr = 3; wb_regwrdata = 16'h0022;
    cyc(); expect_out("dbl_hz", 16'h0012, 3'b000, 1);
    id_rs1addr = 0; cyc(); expect_out("rs1_zero", 16'h0556, 3'b000, 1);
    // Load in MEM is skipped; WB supplies the value, else the register file.
    id_rs1addr = 3; mem_memread = 1; cyc(); expect_out("load_mem", 16'h0023, 3'b000, 1);
    wb_regwraddr = 7; cyc(); expect_out("load_nowb", 16'h0556, 3'b000, 1);
    hz_clear();

    // Store: address from imm, data is forwarded rs2.
    issue(ALU_ADD, 16'h0100, 16'hAAAA, 16'h0004, 1); id_regwrite = 0; id_memwrite = 1;
    id_memtoreg = 2'b01; id_rs2addr = 6; wb_regwrite = 1; wb_regwraddr = 6;
    wb_regwrdata = 16'hBEEF;
    cyc(); expect_out("store", 16'h0104, 3'b000, 1);
    check("store_data", 32'(ex_store_data_out), 32'h0000BEEF);
    check("store_memwrite", 32'(ex_memwrite_out), 1);
    hz_clear();

    issue(ALU_SUB, 16'h8000, 16'h0001, 0, 0); cyc(); expect_out("sub_ovf", 16'h7FFF, 3'b010, 1);
    issue(ALU_AND, 16'h00F0, 16'h000F, 0, 0); cyc(); expect_out("and_z", 16'h0000, 3'b110, 1);
    issue(ALU_LLB, 16'h1234, 0, 16'h00AB, 1); cyc(); expect_out("llb", 16'h12AB, 3'b110, 1);
    issue(ALU_XOR, 16'hFF00, 16'h0F0F, 0, 0); cyc(); expect_out("xor", 16'hF00F, 3'b010, 1);
    issue(ALU_SLL, 16'h0001, 0, 16'h0004, 1); cyc(); expect_out("sll", 16'h0010, 3'b010, 1);
    issue(ALU_SRA, 16'h8000, 0, 16'h0003, 1); cyc(); expect_out("sra", 16'hF000, 3'b010, 1);
    issue(ALU_ROR, 16'h0001, 0, 16'h0001, 1); cyc(); expect_out("ror", 16'h8000, 3'b010, 1);
    issue(ALU_LHB, 16'h1234, 0, 16'h00AB, 1); cyc(); expect_out("lhb", 16'hAB34, 3'b010, 1);
    issue(ALU_OR, 16'h0000, 16'h0000, 0, 0); cyc(); expect_out("or_z", 16'h0000, 3'b110, 1);
    issue(ALU_PASS, 0, 16'h5A5A, 0, 0); cyc(); expect_out("pass", 16'h5A5A, 3'b110, 1);
    idle(); cyc(); expect_out("bubble", 16'h0000, 3'b110, 0);

    // MUL: count stalled cycles, then expect the product with flags held.
    issue(ALU_MUL, 16'h0123, 16'h0010, 0, 0);
    n = 0; gone = 0;
    for (int k = 0; k < 40 && !gone; k++) begin
      #1;
      if (ex_stall) begin n++; cyc(); end
      else gone = 1;
    end
    check("mul_stall_cycles", 32'(n), 17);
    cyc(); expect_out("mul", 16'h1230, 3'b110, 1);
    idle();

    issue(ALU_ADD, 16'hFFFF, 16'h0001, 0, 0); cyc(); expect_out("add_z", 16'h0000, 3'b100, 1);

    // Flush in the middle of a MUL.
    issue(ALU_MUL, 16'h0003, 16'h0005, 0, 0);
    for (int k = 0; k < 5; k++) cyc();
    check("mul_busy_before_flush", 32'(ex_stall), 1);
    flush = 1; #1;
    check("flush_stall_drop", 32'(ex_stall), 0);
    cyc(); expect_out("flush", 16'h0000, 3'b100, 0);
    flush = 0;
    issue(ALU_ADD, 16'h0001, 16'h0001, 0, 0); #1;
    check("post_flush_idle", 32'(ex_stall), 0);
    cyc(); expect_out("post_flush", 16'h0002, 3'b000, 1);

    // Reset in the middle of a MUL.
    issue(ALU_ADD, 16'h7FFF, 16'h0001, 0, 0); cyc(); expect_out("pre_rst", 16'h8000, 3'b011, 1);
    issue(ALU_MUL, 16'h0007, 16'h0009, 0, 0);
    for (int k = 0; k < 3; k++) cyc();
    check("mul_busy_before_rst", 32'(ex_stall), 1);
    #2 rst_n = 0; #1;
    check("rst_mid_stall", 32'(ex_stall), 0);
    expect_out("rst_mid", 16'h0000, 3'b000, 0);
    idle();
    #3 rst_n = 1;
    cyc();
    issue(ALU_ADD, 16'h0002, 16'h0003, 0, 0); cyc(); expect_out("add_after_rst", 16'h0005, 3'b000, 1);
    idle(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_stage_fwd.md
Name: execute_stage_fwd

Overview:
Parametrised EX pipeline stage for the NN soft core. It takes decoded operands, control bits and immediate from ID/EX and applies two-level operand forwarding (EX/MEM over MEM/WB) to both sources and to store data. It executes single-cycle ALU ops plus an iterative multi-cycle multiply that stalls upstream. Results go to a resettable EX/MEM register with valid/bubble tracking, flush support and a Z/V/N flag register.

Parameters:
DATA_W, 16, datapath width (operands, immediate, result)
REG_AW, 4, register address width; address 0 is hardwired zero and is never forwarded
OP_W, 5, ALU opcode width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID/EX holds a real instruction
id_regwrite  in  1  writeback enable
id_memtoreg  in  2  writeback source select (passed through)
id_memread  in  1  load
id_memwrite  in  1  store
id_aluop  in  OP_W  ALU opcode (encodings in package)
id_alusrc  in  1  1 = source 2 is id_imm
id_reg1  in  DATA_W  register-file read data 1
id_reg2  in  DATA_W  register-file read data 2
id_imm  in  DATA_W  sign-extended immediate
id_rs1addr  in  REG_AW  source 1 address
id_rs2addr  in  REG_AW  source 2 address
id_rdaddr  in  REG_AW  destination address
flush  in  1  kill the instruction in EX, including an in-flight multiply
mem_regwrite  in  1  EX/MEM writes a register
mem_memread  in  1  EX/MEM is a load (never forwarded from)
mem_regwraddr  in  REG_AW  EX/MEM destination
mem_aluresult  in  DATA_W  EX/MEM ALU result
wb_regwrite  in  1  MEM/WB writes a register
wb_regwraddr  in  REG_AW  MEM/WB destination
wb_regwrdata  in  DATA_W  MEM/WB writeback data
ex_stall  out  1  hold IF/ID/EX inputs stable this cycle
ex_valid_out  out  1  EX/MEM holds a real instruction
ex_regwrite_out  out  1  registered control
ex_memtoreg_out  out  2  registered control
ex_memread_out  out  1  registered control
ex_memwrite_out  out  1  registered control
ex_alu_out  out  DATA_W  registered result or address
ex_store_data_out  out  DATA_W  registered forwarded source 2 (store data)
ex_regwraddr_out  out  REG_AW  registered destination
flag  out  3  {Z,V,N}

Behaviour:
- Reset (rst_n low, async): every output register and flag is 0, FSM is IDLE, counter is 0, ex_stall is 0.
- Forwarding, per source s in {rs1, rs2}:
  - If mem_regwrite, !mem_memread, mem_regwraddr == s and s != 0, use mem_aluresult.
  - Else if wb_regwrite, wb_regwraddr == s and s != 0, use wb_regwrdata.
  - Else use the register-file value.
- ALU operand 2 is id_imm when id_alusrc = 1. Store data is always forwarded rs2.
- ALU ops: ADD and SUB wrap modulo 2^DATA_W, V is two's-complement overflow. Also XOR, AND, OR, SLL, SRA, ROR (shift amount = operand2[3:0]), LLB, LHB, PASS.
- Flag update happens only when an instruction commits (valid, no flush, not stalled). ADD/SUB update Z, V and N. Logic and shift ops update Z only and hold V and N. All other ops and bubbles hold all flags.
- FSM states IDLE, BUSY, DONE:
  - IDLE: id_valid with MUL and no flush → capture forwarded operands, ex_stall = 1, go to BUSY with count = 0.
  - BUSY: one shift-add step per cycle, ex_stall = 1. At count == DATA_W-1 go to DONE.
  - DONE: ex_stall = 0. EX/MEM loads the low DATA_W bits of the product plus id_* controls. Go to IDLE.
  - For MUL issued in cycle T: ex_stall is high for cycles T..T+DATA_W, and the result is registered at the end of cycle T+DATA_W+1.
- EX/MEM register, every cycle:
  - If flush, or !id_valid, or ex_stall: load a bubble (valid, regwrite, memread, memwrite = 0; data fields 0).
  - Else: load the result.
- flush has priority in any state. FSM goes to IDLE, ex_stall drops combinationally in the same cycle, a bubble is loaded and flags are unchanged.
- Simultaneous MEM and WB match to the same register: MEM wins.
- Reset mid-multiply: abort to IDLE with outputs 0.

Decomposition:
- Package exec_pkg holds the opcode localparams (ALU_ADD … ALU_MUL), the fsm_state_t enum and the flag bit indices.
- One sub-module, exec_mul_iter: start/busy/done iterative shift-add multiplier, parametrised by DATA_W.

Test Plan:
- ADD with r1 = 0x7FFF, r2 = 0x0001, no hazard → next cycle ex_alu_out = 0x8000, flag = {Z0,V1,N1}, ex_valid_out = 1.
- Double hazard: rs1 = 3, mem_regwraddr = 3 with mem_aluresult = 0x0011, wb_regwraddr = 3 with wb_regwrdata = 0x0022; ADD with rs2 value 0x0001 → ex_alu_out = 0x0012. Repeat with rs1 = 0 → value taken from the register file.
- Load in MEM (mem_memread = 1) with matching address → no MEM forward; WB data is used if WB matches.
- MUL 0x0123 × 0x0010 issued at cycle T → ex_stall high for 17 cycles, bubbles on the output, then ex_alu_out = 0x1230 with ex_valid_out = 1.
- flush at cycle T+5 of a MUL → ex_stall low in the same cycle, bubble out, FSM IDLE, flags unchanged.
- rst_n low during BUSY → all outputs 0 immediately. After release, ADD 2+3 → 0x0005.
